// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard unit: load-use stalls plus a non-blocking single-entry mult/div tracker
// with watchdog timeout, sticky error flags and a saturating stall-cycle counter.
module hazard_scoreboard #(
  parameter int unsigned NREG       = 32,
  parameter int unsigned MD_TIMEOUT = 64,
  parameter bit          IGNORE_R0  = 1'b1,
  parameter int unsigned CNT_W      = 32,
  localparam int unsigned RW        = $clog2(NREG)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      fd_ir,
  input  logic [31:0]      dx_ir,
  input  logic             multdiv_ready,
  output logic             stall,
  output logic             md_start,
  output logic             md_busy,
  output logic [RW-1:0]    md_rd,
  output logic [1:0]       err,
  output logic [CNT_W-1:0] stall_count
);

  localparam int unsigned TW = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;

  localparam logic [4:0] OpRtype = 5'b00000;
  localparam logic [4:0] OpLw    = 5'b01000;
  localparam logic [4:0] OpSw    = 5'b00111;
  localparam logic [4:0] OpAddi  = 5'b00101;
  localparam logic [4:0] OpBne   = 5'b00010;
  localparam logic [4:0] OpBlt   = 5'b00110;
  localparam logic [4:0] OpJr    = 5'b00100;
  localparam logic [4:0] AluMult = 5'b00110;
  localparam logic [4:0] AluDiv  = 5'b00111;

  typedef enum logic {StIdle, StBusy} state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [RW-1:0]    md_rd_q, md_rd_d;
  logic [1:0]       err_q, err_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  // Field decode
  logic [4:0] fd_op, fd_rd, fd_rs, fd_rt, fd_alu;
  logic [4:0] dx_op, dx_rd, dx_alu;
  assign fd_op  = fd_ir[31:27];
  assign fd_rd  = fd_ir[26:22];
  assign fd_rs  = fd_ir[21:17];
  assign fd_rt  = fd_ir[16:12];
  assign fd_alu = fd_ir[6:2];
  assign dx_op  = dx_ir[31:27];
  assign dx_rd  = dx_ir[26:22];
  assign dx_alu = dx_ir[6:2];

  logic unused_ir;
  assign unused_ir = ^{fd_ir[11:7], fd_ir[1:0], dx_ir[21:7], dx_ir[1:0]};

  logic fd_is_md, dx_is_md, dx_is_lw;
  assign fd_is_md = (fd_op == OpRtype) && ((fd_alu == AluMult) || (fd_alu == AluDiv));
  assign dx_is_md = (dx_op == OpRtype) && ((dx_alu == AluMult) || (dx_alu == AluDiv));
  assign dx_is_lw = (dx_op == OpLw);

  function automatic logic reg_hit(input logic [4:0] a, input logic [4:0] b);
    return (a == b) && !(IGNORE_R0 && (a == 5'd0));
  endfunction

  // Source and destination registers of the F/D instruction
  logic       src1_vld, src2_vld, wr_vld;
  logic [4:0] src1, src2;

  always_comb begin
    src1_vld = 1'b0;
    src2_vld = 1'b0;
    src1     = fd_rs;
    src2     = fd_rt;
    wr_vld   = 1'b0;
    case (fd_op)
      OpRtype: begin
        src1_vld = 1'b1;
        src2_vld = 1'b1;
        wr_vld   = 1'b1;
      end
      OpAddi, OpLw: begin
        src1_vld = 1'b1;
        wr_vld   = 1'b1;
      end
      OpSw, OpBne, OpBlt: begin
        src1_vld = 1'b1;
        src2_vld = 1'b1;
        src2     = fd_rd;
      end
      OpJr: begin
        src1_vld = 1'b1;
        src1     = fd_rd;
      end
      default: ;
    endcase
  end

  logic       launch, overlap, timeout;
  logic       pend_vld;
  logic [4:0] pend_reg;
  logic       load_use, raw, waw, structural;

  assign launch   = (state_q == StIdle) && dx_is_md;
  assign overlap  = (state_q == StBusy) && dx_is_md;
  assign timeout  = (state_q == StBusy) && !multdiv_ready && (timer_q == TW'(MD_TIMEOUT - 1));

  // The pending destination is visible in the launch cycle so a dependent right behind the
  // mult/div never slips through before the tracker is loaded.
  assign pend_vld = (state_q == StBusy) || launch;
  assign pend_reg = (state_q == StBusy) ? 5'(md_rd_q) : dx_rd;

  assign load_use   = dx_is_lw && ((src1_vld && reg_hit(src1, dx_rd)) ||
                                   (src2_vld && reg_hit(src2, dx_rd)));
  assign raw        = pend_vld && ((src1_vld && reg_hit(src1, pend_reg)) ||
                                   (src2_vld && reg_hit(src2, pend_reg)));
  assign waw        = pend_vld && wr_vld && reg_hit(fd_rd, pend_reg);
  assign structural = pend_vld && fd_is_md;

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    md_rd_d       = md_rd_q;
    err_d         = err_q;
    stall_count_d = stall_count_q;

    unique case (state_q)
      StIdle: begin
        if (launch) begin
          state_d = StBusy;
          timer_d = '0;
          md_rd_d = RW'(dx_rd);
        end
      end
      StBusy: begin
        timer_d = timer_q + TW'(1);
        if (multdiv_ready) begin
          state_d = StIdle;
        end else if (timeout) begin
          state_d  = StIdle;
          err_d[0] = 1'b1;
        end
        if (overlap) begin
          err_d[1] = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (stall && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      timer_q       <= '0;
      md_rd_q       <= '0;
      err_q         <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      md_rd_q       <= md_rd_d;
      err_q         <= err_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall       = load_use || raw || waw || structural;
  assign md_start    = launch;
  assign md_busy     = (state_q == StBusy);
  assign md_rd       = md_rd_q;
  assign err         = err_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard; a second instance with a 4-bit counter
// exercises stall_count saturation.
module tb_hazard_scoreboard;

  logic        clock;
  logic        reset;
  logic [31:0] fd_ir;
  logic [31:0] dx_ir;
  logic        multdiv_ready;

  logic        stall, md_start, md_busy;
  logic [4:0]  md_rd;
  logic [1:0]  err;
  logic [31:0] stall_count;

  logic        stall4, md_start4, md_busy4;
  logic [4:0]  md_rd4;
  logic [1:0]  err4;
  logic [3:0]  stall_count4;

  int n_checks = 0;
  int n_errors = 0;

  hazard_scoreboard dut (
    .clock         (clock),
    .reset         (reset),
    .fd_ir         (fd_ir),
    .dx_ir         (dx_ir),
    .multdiv_ready (multdiv_ready),
    .stall         (stall),
    .md_start      (md_start),
    .md_busy       (md_busy),
    .md_rd         (md_rd),
    .err           (err),
    .stall_count   (stall_count)
  );

  hazard_scoreboard #(.CNT_W(4)) dut4 (
    .clock         (clock),
    .reset         (reset),
    .fd_ir         (fd_ir),
    .dx_ir         (dx_ir),
    .multdiv_ready (multdiv_ready),
    .stall         (stall4),
    .md_start      (md_start4),
    .md_busy       (md_busy4),
    .md_rd         (md_rd4),
    .err           (err4),
    .stall_count   (stall_count4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] alu);
    return {op, rd, rs, rt, 5'b0, alu, 2'b0};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [31:0] lw_r5, add_r7_r5, add_r7_r6, mult_r4, add_r8, sw_r4, addi_r4, div_r9;
  logic [31:0] mult_r6, add_r7_r6b, lw_r0, add_r1_r0;

  initial begin
    lw_r5      = enc(5'b01000, 5'd5, 5'd2, 5'd0, 5'd0);
    add_r7_r5  = enc(5'b00000, 5'd7, 5'd5, 5'd1, 5'd0);
    add_r7_r6  = enc(5'b00000, 5'd7, 5'd6, 5'd1, 5'd0);
    mult_r4    = enc(5'b00000, 5'd4, 5'd2, 5'd3, 5'b00110);
    add_r8     = enc(5'b00000, 5'd8, 5'd1, 5'd2, 5'd0);
    sw_r4      = enc(5'b00111, 5'd4, 5'd1, 5'd0, 5'd0);
    addi_r4    = enc(5'b00101, 5'd4, 5'd1, 5'd0, 5'd0);
    div_r9     = enc(5'b00000, 5'd9, 5'd1, 5'd2, 5'b00111);
    mult_r6    = enc(5'b00000, 5'd6, 5'd1, 5'd2, 5'b00110);
    add_r7_r6b = enc(5'b00000, 5'd7, 5'd6, 5'd1, 5'd0);
    lw_r0      = enc(5'b01000, 5'd0, 5'd2, 5'd0, 5'd0);
    add_r1_r0  = enc(5'b00000, 5'd1, 5'd0, 5'd0, 5'd0);

    reset = 1'b1;
    fd_ir = '0;
    dx_ir = '0;
    multdiv_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check_eq("reset_busy", {31'b0, md_busy}, 32'd0);
    check_eq("reset_rd", {27'b0, md_rd}, 32'd0);
    check_eq("reset_err", {30'b0, err}, 32'd0);
    check_eq("reset_cnt", stall_count, 32'd0);
    check_eq("reset_stall", {31'b0, stall}, 32'd0);
    check_eq("reset_start", {31'b0, md_start}, 32'd0);

    // Load-use: stall one cycle, then nop in D/X releases it
    dx_ir = lw_r5;
    fd_ir = add_r7_r5;
    #1;
    check_eq("lu_stall", {31'b0, stall}, 32'd1);
    tick();
    dx_ir = '0;
    #1;
    check_eq("lu_release", {31'b0, stall}, 32'd0);
    check_eq("lu_cnt", stall_count, 32'd1);
    dx_ir = lw_r5;
    fd_ir = add_r7_r6;
    #1;
    check_eq("lu_indep", {31'b0, stall}, 32'd0);
    tick();

    // Mult launch with independent follower
    dx_ir = mult_r4;
    fd_ir = add_r8;
    #1;
    check_eq("launch_start", {31'b0, md_start}, 32'd1);
    check_eq("launch_indep", {31'b0, stall}, 32'd0);
    tick();
    dx_ir = add_r8;
    fd_ir = sw_r4;
    #1;
    check_eq("busy1_busy", {31'b0, md_busy}, 32'd1);
    check_eq("busy1_rd", {27'b0, md_rd}, 32'd4);
    check_eq("busy1_start", {31'b0, md_start}, 32'd0);
    check_eq("busy1_raw", {31'b0, stall}, 32'd1);
    tick();
    dx_ir = '0;
    fd_ir = addi_r4;
    #1;
    check_eq("waw_stall", {31'b0, stall}, 32'd1);
    fd_ir = div_r9;
    #1;
    check_eq("struct_stall", {31'b0, stall}, 32'd1);
    fd_ir = sw_r4;
    #1;
    for (int c = 3; c <= 9; c++) tick();
    check_eq("busy9_raw", {31'b0, stall}, 32'd1);
    tick();
    multdiv_ready = 1'b1;
    #1;
    check_eq("ready_stall", {31'b0, stall}, 32'd1);
    check_eq("ready_busy", {31'b0, md_busy}, 32'd1);
    tick();
    multdiv_ready = 1'b0;
    #1;
    check_eq("post_busy", {31'b0, md_busy}, 32'd0);
    check_eq("post_stall", {31'b0, stall}, 32'd0);
    check_eq("post_rd", {27'b0, md_rd}, 32'd4);
    check_eq("post_cnt", stall_count, 32'd11);

    // Watchdog timeout
    dx_ir = mult_r6;
    fd_ir = '0;
    #1;
    check_eq("to_start", {31'b0, md_start}, 32'd1);
    tick();
    dx_ir = '0;
    fd_ir = add_r7_r6b;
    #1;
    check_eq("to_dep_stall", {31'b0, stall}, 32'd1);
    for (int c = 2; c <= 64; c++) tick();
    check_eq("to_busy64", {31'b0, md_busy}, 32'd1);
    check_eq("to_err_pre", {30'b0, err}, 32'd0);
    tick();
    check_eq("to_busy_drop", {31'b0, md_busy}, 32'd0);
    check_eq("to_err", {30'b0, err}, 32'd1);
    check_eq("to_issue", {31'b0, stall}, 32'd0);
    check_eq("to_cnt", stall_count, 32'd75);

    // Overlapping launch while busy
    dx_ir = mult_r4;
    fd_ir = '0;
    tick();
    dx_ir = div_r9;
    #1;
    check_eq("ovl_no_start", {31'b0, md_start}, 32'd0);
    tick();
    dx_ir = '0;
    #1;
    check_eq("ovl_err", {30'b0, err}, 32'd3);
    check_eq("ovl_rd", {27'b0, md_rd}, 32'd4);
    check_eq("ovl_busy", {31'b0, md_busy}, 32'd1);

    // Reset mid-operation
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check_eq("mid_rst_busy", {31'b0, md_busy}, 32'd0);
    check_eq("mid_rst_err", {30'b0, err}, 32'd0);
    check_eq("mid_rst_cnt", stall_count, 32'd0);
    check_eq("mid_rst_rd", {27'b0, md_rd}, 32'd0);

    // Register 0 never creates a hazard
    dx_ir = lw_r0;
    fd_ir = add_r1_r0;
    #1;
    check_eq("r0_masked", {31'b0, stall}, 32'd0);

    // multdiv_ready while idle is ignored
    dx_ir = '0;
    fd_ir = '0;
    multdiv_ready = 1'b1;
    tick();
    multdiv_ready = 1'b0;
    #1;
    check_eq("idle_ready_err", {30'b0, err}, 32'd0);
    check_eq("idle_ready_busy", {31'b0, md_busy}, 32'd0);

    // Counter saturation on the 4-bit instance
    dx_ir = lw_r5;
    fd_ir = add_r7_r5;
    for (int c = 0; c < 20; c++) tick();
    check_eq("sat_cnt4", {28'b0, stall_count4}, 32'd15);
    check_eq("sat_cnt32", stall_count, 32'd20);
    dx_ir = '0;
    fd_ir = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Decode-stage hazard unit for the 5-stage pipeline; successor to the single-outstanding load-use/mult-div stall logic.
- Adds a non-blocking multi-cycle (mult/div) tracker: independent instructions keep flowing while a mult/div is in flight.
- Stalls only true RAW/WAW dependents of the pending destination, a second mult/div, and load-use hazards.
- Also provides a watchdog timeout, sticky error flags and a saturating stall-cycle counter.

Parameters:
- NREG, 32: architectural register count; register index width RW = clog2(NREG), 5 at default.
- MD_TIMEOUT, 64: maximum BUSY cycles without multdiv_ready before abort.
- IGNORE_R0, 1: if 1, hazards on register 0 never stall.
- CNT_W, 32: width of the stall-cycle counter.

Ports:
- clock, in, 1: single clock; all state updates on the rising edge.
- reset, in, 1: synchronous, active-high.
- fd_ir, in, 32: instruction in F/D latch.
- dx_ir, in, 32: instruction in D/X latch (all-zero = nop).
- multdiv_ready, in, 1: one-cycle pulse from the mult/div unit; the result is written to md_rd in the same cycle.
- stall, out, 1: freeze PC and F/D, inject nop into D/X.
- md_start, out, 1: launch strobe to the mult/div unit.
- md_busy, out, 1: a mult/div is in flight.
- md_rd, out, RW: destination of the in-flight mult/div.
- err, out, 2: sticky; bit0 = timeout, bit1 = overlapping launch.
- stall_count, out, CNT_W: saturating count of stall cycles.

Behaviour:
- Field decode, fixed ISA:
  - opcode[31:27], rd[26:22], rs[21:17], rt[16:12], aluop[6:2].
  - R-type: opcode 00000; mult: R-type with aluop 00110; div: R-type with aluop 00111.
  - lw: 01000; sw: 00111; addi: 00101; bne: 00010; blt: 00110; jr: 00100.
- FD source registers:
  - R-type: rs, rt.
  - addi, lw: rs.
  - sw, bne, blt: rs and rd.
  - jr: rd.
  - all others: none.
- FD writes a register for R-type, addi, lw; that register is rd.
- A register match on index 0 is masked when IGNORE_R0=1.
- Launch condition (combinational): state IDLE and dx_ir is mult/div.
  - md_start = 1 exactly in that cycle.
  - At the edge: md_rd <= dx rd, state <= BUSY, timer <= 0.
- Pending destination P:
  - In BUSY: P = md_rd.
  - During the launch cycle: P = dx rd.
  - Otherwise: no P.
- stall = OR of:
  - (a) load-use: dx_ir is lw and an FD source equals dx rd;
  - (b) RAW: P valid and an FD source equals P;
  - (c) WAW: P valid and FD write register equals P;
  - (d) structural: P valid and fd_ir is mult/div.
- stall is combinational, with no added latency.
- FSM: two states, IDLE and BUSY.
  - IDLE -> BUSY on launch.
  - BUSY -> IDLE on multdiv_ready.
  - BUSY -> IDLE on timeout: timer reaches MD_TIMEOUT-1 with multdiv_ready=0. Also set err[0].
  - In BUSY, timer increments each cycle.
- md_busy = (state == BUSY).
  - md_busy and md_rd hold across the multdiv_ready cycle.
  - Both clear on the following edge.
  - md_rd resets to 0 and keeps its last value in IDLE.
- Ready cycle: multdiv_ready does NOT release the stall combinationally; no bypass. A dependent in FD stalls through the ready cycle and issues the next cycle.
- Overlap: a mult/div in dx_ir while BUSY is a protocol violation.
  - No launch; set err[1].
  - The current operation continues.
- multdiv_ready while IDLE is ignored and has no error.
- stall_count increments on every cycle with stall=1 and saturates at all-ones.
- Synchronous reset, including mid-operation. The cycle after reset has:
  - state IDLE, md_busy=0, md_rd=0;
  - err=00, stall_count=0, timer=0;
  - md_start and stall driven purely by the current fd_ir/dx_ir.
- No output is reset to X.

Test Plan:
- Reset, then dx_ir=lw r5,0(r2) and fd_ir=add r7,r5,r1 -> stall=1 for exactly 1 cycle; stall_count=1. Repeat with fd_ir=add r7,r6,r1 -> stall=0.
- dx_ir=mult r4,r2,r3 -> md_start=1 for 1 cycle, then md_busy=1 and md_rd=4. Independent add r8,r1,r2 issues with stall=0. Then fd_ir=sw r4,0(r1) -> stall=1 until 1 cycle after a multdiv_ready pulse in busy cycle 10.
- While BUSY with md_rd=4: fd_ir=addi r4,r1,3 -> stall=1 (WAW); fd_ir=div r9,r1,r2 -> stall=1 (structural).
- Launch with multdiv_ready never pulsed (MD_TIMEOUT=64) -> md_busy drops after 64 busy cycles; err=01; a stalled dependent issues the next cycle.
- Force dx_ir=div while BUSY -> err[1]=1, md_rd unchanged, no md_start. Assert reset mid-BUSY -> next cycle md_busy=0, err=00, stall_count=0.
- With IGNORE_R0=1: dx_ir=lw r0 and fd_ir=add r1,r0,r0 -> stall=0. With CNT_W=4, hold stall for 20 cycles -> stall_count=15.
